// File: rtl/noc_credit_tx.sv
// Credit-based flit sender: a 2-entry skid buffer feeding a registered output stage.
// A flit goes downstream only while credits remain for the downstream buffer.
module noc_credit_tx #(
    parameter int  FLIT_WIDTH = 32,
    parameter int  CREDITS    = 17,
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  credit_in,
    output logic [CW-1:0]         credits,
    output logic                  pkt_active,
    output logic                  credit_err
);

    localparam int           EW          = FLIT_WIDTH + 1;
    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    // Skid buffer state
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic [1:0]    count_next;
    logic [EW-1:0] entry_data [2];
    logic [EW-1:0] head_data;

    // Output stage and credit state
    logic [FLIT_WIDTH-1:0] out_flit_reg;
    logic                  out_last_reg;
    logic                  out_valid_reg;
    logic [CW-1:0]         credits_reg;
    logic [CW-1:0]         credits_next;
    logic                  credit_err_reg;
    pkt_state_t            state_reg;
    pkt_state_t            state_next;

    logic accept;
    logic send;

    // in_ready looks only at the skid occupancy, never at the credit counter.
    assign in_ready = (count_reg != 2'd2);
    assign accept   = in_valid & in_ready;
    assign send     = (count_reg != 2'd0) & (credits_reg != '0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [EW-1:0] data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (accept && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= {in_last, in_flit};
                end
            end

            assign entry_data[gi] = data_reg;
        end
    endgenerate

    assign head_data = rd_ptr_reg ? entry_data[1] : entry_data[0];

    always_comb begin
        count_next = count_reg;
        case ({accept, send})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (send) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flit_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= send;
            if (send) begin
                out_flit_reg <= head_data[FLIT_WIDTH-1:0];
                out_last_reg <= head_data[EW-1];
            end
        end
    end

    // A credit returned while full saturates the counter and is flagged.
    always_comb begin
        credits_next = credits_reg;
        if (send && !credit_in) begin
            credits_next = credits_reg - CW'(1);
        end else if (credit_in && !send && (credits_reg != CREDITS_MAX)) begin
            credits_next = credits_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_reg    <= CREDITS_MAX;
            credit_err_reg <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            if (credit_in && !send && (credits_reg == CREDITS_MAX)) begin
                credit_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (send) begin
            case (state_reg)
                IDLE:    state_next = head_data[EW-1] ? IDLE : IN_PKT;
                IN_PKT:  state_next = head_data[EW-1] ? IDLE : IN_PKT;
                default: state_next = IDLE;
            endcase
        end
    end

    assign out_flit   = out_flit_reg;
    assign out_last   = out_last_reg;
    assign out_valid  = out_valid_reg;
    assign credits    = credits_reg;
    assign pkt_active = (state_reg == IN_PKT);
    assign credit_err = credit_err_reg;

endmodule
